inst_fetch_sequencer: RTL and testbench

//  Sequences the byte-wide, combinational-read Instruction_Memory to deliver
//  32-bit little-endian instructions to decode via a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/inst_byte_assembler.sv | 37 +++
 rtl/inst_fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM encoding and the fetch-target legality check.
package fetch_pkg;

    localparam int XLEN       = 64;
    localparam int INST_BYTES = 4;
    localparam int BYTE_IDX_W = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // Target is illegal when misaligned or when the whole instruction does not fit below limit.
    function automatic logic fetch_target_bad(input logic [XLEN-1:0] addr,
                                              input logic [XLEN:0]   limit);
        logic [XLEN:0] end_s;
        end_s = {1'b0, addr} + (XLEN+1)'(INST_BYTES);
        return (addr[1:0] != 2'b00) || (end_s > limit);
    endfunction

endpackage

// File: rtl/inst_byte_assembler.sv
// Four byte lanes gathered one at a time into a 32-bit little-endian word.
// Lane 0 is the least significant byte of the assembled instruction.
module inst_byte_assembler
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [BYTE_IDX_W-1:0] lane_sel,
    input  logic [7:0]            wr_byte,
    output logic [31:0]           word
);

    logic [7:0] lanes_r [INST_BYTES];

    // Lane storage: clear wins over write.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < INST_BYTES; i++) begin
                lanes_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            lanes_r[lane_sel] <= wr_byte;
        end else begin
            lanes_r[lane_sel] <= lanes_r[lane_sel];
        end
    end

    // Concatenate lanes, lane 0 at bits [7:0].
    always_comb begin
        word = 32'h0000_0000;
        for (int i = 0; i < INST_BYTES; i++) begin
            word[i*8 +: 8] = lanes_r[i];
        end
    end

endmodule

// File: rtl/inst_fetch_sequencer.sv
// Owns the PC and walks a byte-wide memory to present 32-bit instructions
// to decode over valid/ready; redirects reload the PC and drop partial fetches.
module inst_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned MEM_BYTES = 16
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    output logic [XLEN-1:0] mem_addr,
    input  logic [7:0]      mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault
);

    localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    fetch_state_e          state_r, state_s;
    logic [XLEN-1:0]       pc_r, pc_s;
    logic [BYTE_IDX_W-1:0] byte_idx_r, byte_idx_s;
    logic                  inst_valid_r, inst_valid_s;
    logic [XLEN-1:0]       inst_pc_r, inst_pc_s;
    logic                  fault_r, fault_s;
    logic [XLEN-1:0]       mem_addr_r, mem_addr_s;
    logic                  capture_s;
    logic                  lane_clr_s;

    // Next-state, PC and handshake decisions; redirect takes priority over everything.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        byte_idx_s   = byte_idx_r;
        inst_valid_s = inst_valid_r;
        inst_pc_s    = inst_pc_r;
        fault_s      = fault_r;
        capture_s    = 1'b0;
        if (redirect_valid) begin
            pc_s         = redirect_pc;
            byte_idx_s   = 2'd0;
            inst_valid_s = 1'b0;
            if (fetch_target_bad(redirect_pc, MEM_LIMIT)) begin
                state_s = FAULT;
                fault_s = 1'b1;
            end else begin
                state_s = FETCH;
                fault_s = 1'b0;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if ((byte_idx_r == 2'd0) && fetch_target_bad(pc_r, MEM_LIMIT)) begin
                        state_s      = FAULT;
                        fault_s      = 1'b1;
                        inst_valid_s = 1'b0;
                    end else if (enable) begin
                        capture_s = 1'b1;
                        if (byte_idx_r == 2'd3) begin
                            byte_idx_s   = 2'd0;
                            inst_valid_s = 1'b1;
                            inst_pc_s    = pc_r;
                            state_s      = HOLD;
                        end else begin
                            byte_idx_s = byte_idx_r + 2'd1;
                        end
                    end else begin
                        byte_idx_s = byte_idx_r;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc_s         = pc_r + 64'd4;
                        byte_idx_s   = 2'd0;
                        inst_valid_s = 1'b0;
                        // Check the sequential target now so no cycle is spent in FETCH.
                        if (fetch_target_bad(pc_r + 64'd4, MEM_LIMIT)) begin
                            state_s = FAULT;
                            fault_s = 1'b1;
                        end else begin
                            state_s = FETCH;
                        end
                    end else begin
                        state_s = HOLD;
                    end
                end
                FAULT: begin
                    state_s = FAULT;
                end
                default: begin
                    state_s      = FETCH;
                    byte_idx_s   = 2'd0;
                    inst_valid_s = 1'b0;
                end
            endcase
        end
        mem_addr_s = pc_s + XLEN'(byte_idx_s);
    end

    // Sequential state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            byte_idx_r   <= 2'd0;
            inst_valid_r <= 1'b0;
            inst_pc_r    <= 64'd0;
            fault_r      <= 1'b0;
            mem_addr_r   <= RESET_PC;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            byte_idx_r   <= byte_idx_s;
            inst_valid_r <= inst_valid_s;
            inst_pc_r    <= inst_pc_s;
            fault_r      <= fault_s;
            mem_addr_r   <= mem_addr_s;
        end
    end

    assign lane_clr_s = !reset_n || redirect_valid;

    inst_byte_assembler u_assembler (
        .clk      (clk),
        .clr      (lane_clr_s),
        .wr_en    (capture_s),
        .lane_sel (byte_idx_r),
        .wr_byte  (mem_rdata),
        .word     (inst_data)
    );

    assign mem_addr   = mem_addr_r;
    assign inst_valid = inst_valid_r;
    assign inst_pc    = inst_pc_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Randomized and directed bench for inst_fetch_sequencer against a
// transaction-level model of PC progress, byte count and fault status.
module tb_inst_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, enable, redirect_valid, inst_ready;
    logic [63:0] mem_addr, redirect_pc, inst_pc;
    logic [7:0]  mem_rdata;
    logic        inst_valid, fault;
    logic [31:0] inst_data;

    logic [7:0]  mem [0:15];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [63:0] m_pc;
    int          m_got;
    bit          m_fault;

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 64'd16) ? mem[mem_addr[3:0]] : 8'h00;

    inst_fetch_sequencer #(.RESET_PC(64'd0), .MEM_BYTES(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .fault(fault)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a > 64'd12);
    endfunction

    function automatic logic [31:0] m_word(input logic [63:0] a);
        logic [3:0] b;
        b = a[3:0];
        return {mem[b + 4'd3], mem[b + 4'd2], mem[b + 4'd1], mem[b]};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit exp_valid;
        logic [63:0] exp_addr;
        @(posedge clk);
        if (!reset_n) begin
            m_pc = 64'd0; m_got = 0; m_fault = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_got = 0; m_fault = m_bad(redirect_pc);
        end else if (m_fault) begin
            m_got = 0;
        end else if (m_got == 4) begin
            if (inst_ready) begin
                m_pc = m_pc + 64'd4; m_got = 0; m_fault = m_bad(m_pc);
            end
        end else if (m_got == 0 && m_bad(m_pc)) begin
            m_fault = 1'b1;
        end else if (enable) begin
            m_got++;
        end
        #1;
        exp_valid = !m_fault && (m_got == 4);
        exp_addr  = (m_fault || m_got == 4) ? m_pc : m_pc + 64'(m_got);
        check_value("fault", 64'(fault), 64'(m_fault));
        check_value("inst_valid", 64'(inst_valid), 64'(exp_valid));
        check_value("mem_addr", mem_addr, exp_addr);
        if (exp_valid) begin
            check_value("inst_data", 64'(inst_data), 64'(m_word(m_pc)));
            check_value("inst_pc", inst_pc, m_pc);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; enable = 1'b1; inst_ready = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  init_bytes [16];
        logic [31:0] exp_words [4];
        logic [63:0] targets [6];
        init_bytes = '{8'h83, 8'h34, 8'h85, 8'h02, 8'hB3, 8'h84, 8'h9A, 8'h00,
                       8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02};
        exp_words  = '{32'h02853483, 32'h009A84B3, 32'h00148493, 32'h02953423};
        targets    = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd6, 64'd16};
        for (int i = 0; i < 16; i++) mem[i] = init_bytes[i];
        redirect_pc = 64'd0;

        // Reset state and streaming of all four instructions.
        do_reset();
        check_value("rst_inst_data", 64'(inst_data), 64'd0);
        check_value("rst_inst_pc", inst_pc, 64'd0);
        for (int k = 0; k < 4; k++) begin
            repeat (4) step();
            check_value("t1_valid", 64'(inst_valid), 64'd1);
            check_value("t1_data", 64'(inst_data), 64'(exp_words[k]));
            check_value("t1_pc", inst_pc, 64'(4 * k));
            step();
            check_value("t1_one_cycle", 64'(inst_valid), 64'd0);
        end
        check_value("t2_fault", 64'(fault), 64'd1);
        repeat (3) step();
        check_value("t2_fault_held", 64'(fault), 64'd1);

        // Backpressure in HOLD.
        do_reset();
        inst_ready = 1'b0;
        repeat (4) step();
        inst_ready = 1'b1; step(); inst_ready = 1'b0;
        repeat (4) step();
        repeat (10) step();
        check_value("t3_hold_data", 64'(inst_data), 64'h009A84B3);
        check_value("t3_hold_valid", 64'(inst_valid), 64'd1);
        inst_ready = 1'b1; step(); inst_ready = 1'b0;
        repeat (4) step();
        check_value("t3_next_data", 64'(inst_data), 64'h00148493);
        check_value("t3_next_pc", inst_pc, 64'd8);

        // Redirect mid-fetch, to a misaligned target, then back to zero.
        do_reset();
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 64'd8; step(); redirect_valid = 1'b0;
        repeat (4) step();
        check_value("t4_data", 64'(inst_data), 64'h00148493);
        check_value("t4_pc", inst_pc, 64'd8);
        redirect_valid = 1'b1; redirect_pc = 64'd6; step();
        check_value("t4_fault_set", 64'(fault), 64'd1);
        redirect_pc = 64'd0; step(); redirect_valid = 1'b0;
        check_value("t4_fault_clr", 64'(fault), 64'd0);

        // Enable stall, then reset in the middle of a fetch.
        do_reset();
        step();
        enable = 1'b0;
        repeat (3) step();
        check_value("t5_addr_frozen", mem_addr, 64'd1);
        enable = 1'b1;
        repeat (3) step();
        check_value("t5_data", 64'(inst_data), 64'h02853483);
        do_reset();
        repeat (2) step();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        check_value("t5_rst_addr", mem_addr, 64'd0);
        check_value("t5_rst_valid", 64'(inst_valid), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset_n        = ($urandom_range(0, 99) != 0);
            enable         = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 1) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = {$urandom(), $urandom()};
            else
                redirect_pc = targets[$urandom_range(0, 5)];
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
